page_buf_sched: RTL

Sequences ownership of the 2048-word page buffer between the host port and the NAND-controller port for one page transfer at a time. Accepts a page command (PROGRAM: host fills, NAND side drains; READ: NAND side fills, host drains) and gates every buffer strobe so only the legal writer/reader is active. Counts words on each side, enforces a per-word stall timeout and reports completion or error. Sits between the command decoder and the page buffer, and is the only driver of the buffer's select and strobe inputs.

---
 rtl/page_buf_pkg.sv | 19 +
 rtl/page_buf_sched_xfer_counter.sv | 44 ++++
 rtl/page_buf_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/page_buf_pkg.sv
// Shared types and constants for the page buffer ownership scheduler.
package page_buf_pkg;

  localparam int DEF_BUF_DEPTH = 2048;
  localparam int DEF_TIMEOUT   = 1024;

  localparam logic OP_PROGRAM = 1'b0;
  localparam logic OP_READ    = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_HOST_FILL  = 3'd1,
    ST_NAND_DRAIN = 3'd2,
    ST_NAND_FILL  = 3'd3,
    ST_HOST_DRAIN = 3'd4,
    ST_FLUSH      = 3'd5
  } state_e;

endpackage

// File: rtl/page_buf_sched_xfer_counter.sv
// Word counter and stall timer shared by whichever transfer phase is active.
module xfer_counter
  import page_buf_pkg::*;
#(
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int CNT_W     = $clog2(BUF_DEPTH) + 1,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_strobe,
  input  logic             i_active,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last,
  output logic             o_timeout
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [TMR_W-1:0] r_timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_timer <= '0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_timer <= '0;
    end else if (i_strobe) begin
      r_cnt   <= r_cnt + 1'b1;
      r_timer <= '0;
    end else if (i_active) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Timeout fires on the idle cycle that would bring the timer up to TIMEOUT.
  assign o_cnt     = r_cnt;
  assign o_last    = i_strobe && (r_cnt == CNT_W'(BUF_DEPTH - 1));
  assign o_timeout = i_active && !i_strobe && (r_timer == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/page_buf_sched.sv
// Hands page buffer ownership between host and NAND controller for one page
// transfer, gating every buffer strobe and reporting completion or error.
module page_buf_sched
  import page_buf_pkg::*;
#(
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int CNT_W     = $clog2(BUF_DEPTH) + 1,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cmd_valid,
  input  logic             i_cmd_op,
  output logic             o_cmd_ready,
  input  logic             i_abort,
  input  logic             i_host_wr_req,
  input  logic             i_host_rd_req,
  input  logic             i_nand_wr_req,
  input  logic             i_nand_rd_req,
  output logic             o_buf_sel,
  output logic             o_buf_we,
  output logic             o_buf_re,
  output logic             o_cntrl_sel,
  output logic             o_cntrl_we,
  output logic             o_cntrl_re,
  output logic             o_host_rd_vld,
  output logic             o_nand_rd_vld,
  output logic [CNT_W-1:0] o_host_cnt,
  output logic [CNT_W-1:0] o_nand_cnt,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  state_e r_state;
  state_e w_state_next;
  logic   r_op;
  logic   r_phase2;
  logic   r_done;
  logic   r_err;
  logic   r_host_rd_vld;
  logic   r_nand_rd_vld;

  logic             w_accept;
  logic             w_clr;
  logic             w_finish;
  logic             w_fail;
  logic             w_enter_drain;
  logic             w_buf_we;
  logic             w_buf_re;
  logic             w_cntrl_we;
  logic             w_cntrl_re;
  logic             w_active;
  logic             w_strobe;
  logic             w_last;
  logic             w_timeout;
  logic [CNT_W-1:0] w_cnt;

  assign w_accept   = (r_state == ST_IDLE) && i_cmd_valid;
  assign w_buf_we   = (r_state == ST_HOST_FILL)  && i_host_wr_req;
  assign w_buf_re   = (r_state == ST_HOST_DRAIN) && i_host_rd_req;
  assign w_cntrl_we = (r_state == ST_NAND_FILL)  && i_nand_wr_req;
  assign w_cntrl_re = (r_state == ST_NAND_DRAIN) && i_nand_rd_req;
  assign w_strobe   = w_buf_we | w_buf_re | w_cntrl_we | w_cntrl_re;
  assign w_active   = (r_state == ST_HOST_FILL) || (r_state == ST_HOST_DRAIN) ||
                      (r_state == ST_NAND_FILL) || (r_state == ST_NAND_DRAIN);

  xfer_counter #(
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_xfer_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_strobe  (w_strobe),
    .i_active  (w_active),
    .o_cnt     (w_cnt),
    .o_last    (w_last),
    .o_timeout (w_timeout)
  );

  // Abort and timeout take priority over a coincident final strobe.
  always_comb begin
    w_state_next  = r_state;
    w_clr         = 1'b0;
    w_finish      = 1'b0;
    w_fail        = 1'b0;
    w_enter_drain = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          w_clr        = 1'b1;
          w_state_next = (i_cmd_op == OP_READ) ? ST_NAND_FILL : ST_HOST_FILL;
        end
      end
      ST_HOST_FILL, ST_NAND_FILL: begin
        if (i_abort || w_timeout) begin
          w_fail       = 1'b1;
          w_state_next = ST_FLUSH;
        end else if (w_last) begin
          w_clr         = 1'b1;
          w_enter_drain = 1'b1;
          w_state_next  = (r_state == ST_HOST_FILL) ? ST_NAND_DRAIN : ST_HOST_DRAIN;
        end
      end
      ST_NAND_DRAIN, ST_HOST_DRAIN: begin
        if (i_abort || w_timeout) begin
          w_fail       = 1'b1;
          w_state_next = ST_FLUSH;
        end else if (w_last) begin
          w_finish     = 1'b1;
          w_state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_PROGRAM;
      r_phase2      <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_host_rd_vld <= 1'b0;
      r_nand_rd_vld <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_done        <= w_finish;
      r_err         <= w_fail;
      r_host_rd_vld <= w_buf_re;
      r_nand_rd_vld <= w_cntrl_re;
      if (w_accept) begin
        r_op     <= i_cmd_op;
        r_phase2 <= 1'b0;
      end else if (w_enter_drain) begin
        r_phase2 <= 1'b1;
      end
    end
  end

  // The shared counter tracks the current phase; a completed fill phase
  // always moved exactly BUF_DEPTH words.
  always_comb begin
    if (r_op == OP_PROGRAM) begin
      o_host_cnt = r_phase2 ? CNT_W'(BUF_DEPTH) : w_cnt;
      o_nand_cnt = r_phase2 ? w_cnt : '0;
    end else begin
      o_host_cnt = r_phase2 ? w_cnt : '0;
      o_nand_cnt = r_phase2 ? CNT_W'(BUF_DEPTH) : w_cnt;
    end
  end

  assign o_cmd_ready   = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_buf_sel     = (r_state == ST_HOST_FILL) || (r_state == ST_HOST_DRAIN);
  assign o_cntrl_sel   = (r_state == ST_NAND_FILL) || (r_state == ST_NAND_DRAIN);
  assign o_buf_we      = w_buf_we;
  assign o_buf_re      = w_buf_re;
  assign o_cntrl_we    = w_cntrl_we;
  assign o_cntrl_re    = w_cntrl_re;
  assign o_host_rd_vld = r_host_rd_vld;
  assign o_nand_rd_vld = r_nand_rd_vld;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule
